// File: rtl/mask_scan_ctrl.sv
// rtl/mask_scan_ctrl.sv - raster-scan mask controller: ROM address counters, masked pixel register
// One pixel per cycle through a single output register; backpressure stalls scan and input.
module mask_scan_ctrl #(
   parameter int COLS = 160,
   parameter int ROWS = 120
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        mask_en,
   input  logic [11:0] in_pixel,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [6:0]  rom_row,
   output logic [7:0]  rom_col,
   input  logic [11:0] rom_data,
   output logic [11:0] out_pixel,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic        frame_done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   localparam logic [7:0] COL_LAST = 8'(COLS - 1);
   localparam logic [6:0] ROW_LAST = 7'(ROWS - 1);

   state_t      state_q, state_d;
   logic [6:0]  row_q, row_d;
   logic [7:0]  col_q, col_d;
   logic [11:0] out_pixel_q, out_pixel_d;
   logic        out_valid_q, out_valid_d;
   logic        out_last_q, out_last_d;
   logic        frame_done_q, frame_done_d;

   logic accept;
   logic out_hs;
   logic last_px;

   assign accept  = in_valid & in_ready;
   assign out_hs  = out_valid_q & out_ready;
   assign last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (accept && last_px) state_d = S_DRAIN;
         S_DRAIN: if (out_hs && out_last_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
      busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
   end

   always_comb begin
      row_d        = row_q;
      col_d        = col_q;
      out_pixel_d  = out_pixel_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      frame_done_d = out_hs && out_last_q;
      if ((state_q == S_IDLE) && start) begin
         row_d = 7'd0;
         col_d = 8'd0;
      end
      if (accept) begin
         out_pixel_d = mask_en ? (in_pixel & rom_data) : in_pixel;
         out_valid_d = 1'b1;
         out_last_d  = last_px;
         // Column wraps into the next row; the frame's last pixel returns the scan to 0/0.
         if (col_q == COL_LAST) begin
            col_d = 8'd0;
            row_d = (row_q == ROW_LAST) ? 7'd0 : row_q + 7'd1;
         end else begin
            col_d = col_q + 8'd1;
         end
      end else if (out_hs) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q        <= 7'd0;
         col_q        <= 8'd0;
         out_pixel_q  <= 12'd0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         row_q        <= row_d;
         col_q        <= col_d;
         out_pixel_q  <= out_pixel_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign rom_row    = row_q;
   assign rom_col    = col_q;
   assign out_pixel  = out_pixel_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mask_scan_ctrl.sv
// tb/tb_mask_scan_ctrl.sv - directed bench for mask_scan_ctrl with a pixel-index reference model
module tb_mask_scan_ctrl;

   localparam int COLS  = 160;
   localparam int ROWS  = 120;
   localparam int FRAME = COLS * ROWS;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mask_en = 1'b1;
   logic [11:0] in_pixel = 12'hFFF;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  rom_row;
   logic [7:0]  rom_col;
   logic [11:0] rom_data;
   logic [11:0] out_pixel;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_last;
   logic        busy;
   logic        frame_done;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign rom_data = {rom_row[3:0], rom_col};

   mask_scan_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mask_en(mask_en),
      .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
      .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
      .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .frame_done(frame_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: frame position is a single accepted-pixel index k; row/col derive from it.
   function automatic logic [11:0] rom_fn(input int k);
      logic [6:0] r;
      logic [7:0] c;
      r = 7'(k / COLS);
      c = 8'(k % COLS);
      return {r[3:0], c};
   endfunction

   int          m_mode = 0;
   int          m_k = 0;
   logic        p_valid = 1'b0;
   logic [11:0] p_pix = 12'd0;
   logic        p_last = 1'b0;
   int          p_idx = 0;
   logic        m_fd = 1'b0;
   int          dut_outs = 0;

   function automatic logic exp_ready();
      return (m_mode == 1) && (!p_valid || out_ready);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode  <= 0;
         m_k     <= 0;
         p_valid <= 1'b0;
         p_pix   <= 12'd0;
         p_last  <= 1'b0;
         p_idx   <= 0;
         m_fd    <= 1'b0;
      end else begin
         m_fd <= p_valid && out_ready && p_last;
         if (m_mode == 0 && start) m_mode <= 1;
         else if (m_mode == 1 && in_valid && exp_ready() && m_k == FRAME - 1) m_mode <= 2;
         else if (m_mode == 2 && p_valid && out_ready && p_last) m_mode <= 0;
         if (in_valid && exp_ready()) begin
            p_valid <= 1'b1;
            p_pix   <= mask_en ? (in_pixel & rom_fn(m_k)) : in_pixel;
            p_last  <= (m_k == FRAME - 1);
            p_idx   <= m_k;
            m_k     <= (m_k == FRAME - 1) ? 0 : m_k + 1;
         end else if (p_valid && out_ready) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) dut_outs <= dut_outs + 1;
   end

   int   frame_no = 0;
   logic bp_active = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", in_ready, exp_ready());
         chk("rom_row", rom_row, 32'(m_k / COLS));
         chk("rom_col", rom_col, 32'(m_k % COLS));
         chk("out_valid", out_valid, p_valid);
         chk("out_last", out_last, p_last);
         chk("busy", busy, m_mode != 0);
         chk("frame_done", frame_done, m_fd);
         if (p_valid) chk("out_pixel", out_pixel, p_pix);
         if (frame_no == 1 && p_valid && p_idx == 3448) chk("mask_r21_c88", out_pixel, 12'h508);
         if (frame_no == 1 && p_valid && p_idx == 3449) chk("nomask_r21_c89", out_pixel, 12'hF0F);
         if (frame_no == 1 && m_mode == 1 && m_k == 960) begin
            chk("wrap_row", rom_row, 7'd6);
            chk("wrap_col", rom_col, 8'd0);
         end
         if (m_mode == 2) chk("drain_addr", {rom_row, rom_col}, 15'd0);
         if (frame_no == 1 && bp_active) begin
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_rom_col", rom_col, 8'd40);
            chk("bp_out_valid", out_valid, 1'b1);
         end
      end
   end

   int bp_left = 0;
   logic bp_done = 1'b0;

   task automatic run_until_done(input int budget, output logic ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk); #1;
         if (m_fd) begin
            ok = 1'b1;
            break;
         end
         in_pixel = (frame_no == 1 && (m_k == 3448 || m_k == 3449)) ? 12'hF0F : 12'hFFF;
         mask_en  = !(frame_no == 1 && m_k == 3449);
         if (frame_no == 1 && m_k == 1000 && !bp_done) begin
            bp_left = 5;
            bp_done = 1'b1;
         end
         out_ready = (bp_left == 0);
         bp_active = (bp_left != 0);
         if (bp_left > 0) bp_left--;
      end
      bp_active = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      logic ok;
      int   base;
      #12;
      chk("reset_busy", busy, 1'b0);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_addr", {rom_row, rom_col}, 15'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      frame_no = 1;
      base = dut_outs;
      @(posedge clk); #1;
      start = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      run_until_done(FRAME + 200, ok);
      chk("frame1_done_seen", ok, 1'b1);
      chk("frame1_outputs", dut_outs - base, FRAME);

      frame_no = 2;
      in_valid = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         chk("idle_in_ready", in_ready, 1'b0);
      end
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk); #1;
         start = (m_k == 200);
         if (m_k == 500) begin
            ok = 1'b1;
            break;
         end
      end
      chk("reach_px500", ok, 1'b1);
      start = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_pixel", out_pixel, 12'd0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_addr", {rom_row, rom_col}, 15'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("post_rst_idle", busy, 1'b0);

      frame_no = 3;
      base = dut_outs;
      start = 1'b1;
      run_until_done(FRAME + 200, ok);
      chk("frame3_done_seen", ok, 1'b1);
      chk("frame3_outputs", dut_outs - base, FRAME);
      chk("restart_state_idle", busy, 1'b0);
      @(posedge clk); #1;
      chk("restart_busy", busy, 1'b1);
      repeat (3) @(posedge clk);
      #1 start = 1'b0;
      chk("restart_progress", {rom_row, rom_col}, 15'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mask_scan_ctrl.md
MASK_SCAN_CTRL -- requirements
Module: mask_scan_ctrl

Interface
REQ-001 Parameter: COLS, 160, mask columns per row (col index 0..COLS-1).
REQ-002 Parameter: ROWS, 120, mask rows per frame (row index 0..ROWS-1).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  frame start request; sampled in IDLE only.
REQ-006 Port: mask_en  input  1  1 = apply mask, 0 = pass pixel through; sampled per accepted pixel.
REQ-007 Port: in_pixel  input  12  incoming pixel colour.
REQ-008 Port: in_valid  input  1  in_pixel valid.
REQ-009 Port: in_ready  output  1  controller accepts in_pixel this cycle.
REQ-010 Port: rom_row  output  7  row address to mask ROM.
REQ-011 Port: rom_col  output  8  column address to mask ROM.
REQ-012 Port: rom_data  input  12  mask ROM colour data, combinational from rom_row/rom_col.
REQ-013 Port: out_pixel  output  12  masked pixel.
REQ-014 Port: out_valid  output  1  out_pixel valid.
REQ-015 Port: out_ready  input  1  downstream accepts out_pixel.
REQ-016 Port: out_last  output  1  qualifies final pixel of frame (row ROWS-1, col COLS-1).
REQ-017 Port: busy  output  1  high in RUN and DRAIN.
REQ-018 Port: frame_done  output  1  one-cycle pulse after final pixel handshaken on output.

Function
REQ-019 FSM states IDLE, RUN, DRAIN; IDLE -> RUN when start=1; RUN -> DRAIN when final pixel accepted on input; DRAIN -> IDLE when out_valid & out_ready & out_last.
REQ-020 rom_row/rom_col are registered scan counters; both 0 in IDLE; start loads 0/0.
REQ-021 in_ready = (state==RUN) & (!out_valid | out_ready); zero in IDLE and DRAIN.
REQ-022 Input accept = in_valid & in_ready; on accept, out_pixel <= mask_en ? (in_pixel & rom_data) : in_pixel, using rom_data for current rom_row/rom_col; out_valid <= 1; latency accept -> out_valid is one cycle.
REQ-023 On accept, rom_col increments; at rom_col==COLS-1 it wraps to 0 and rom_row increments; at rom_row==ROWS-1 & rom_col==COLS-1 counters return to 0/0 and out_last <= 1 with that pixel.
REQ-024 out_valid clears on out_ready when no new accept in same cycle; simultaneous output handshake and input accept keeps out_valid=1 with new data (full throughput, one pixel per cycle).
REQ-025 While out_valid=1 & out_ready=0, out_pixel, out_last and counters hold; no input accepted.
REQ-026 frame_done asserts for exactly one cycle, the cycle after the out_last handshake; state is IDLE in that cycle.
REQ-027 start asserted outside IDLE is ignored; start held high continuously restarts a new frame from the IDLE cycle in which frame_done is high.
REQ-028 in_valid while IDLE or DRAIN is ignored and not consumed.
REQ-029 Counter widths: rom_col 8 bits, rom_row 7 bits; no address outside 0..COLS-1 / 0..ROWS-1 is ever driven.

Reset
REQ-030 rst_n low asynchronously forces IDLE, rom_row=0, rom_col=0, out_pixel=0, out_valid=0, out_last=0, frame_done=0, in_ready=0, busy=0.
REQ-031 Reset mid-frame discards the partial frame and pending output; operation resumes only on a new start after rst_n high.

Verification
REQ-032 Reset then start, in_valid=1, out_ready=1, mask_en=1, in_pixel=12'hFFF, ROM model returns {row[3:0],col[7:0]} -> out_pixel equals ROM value each cycle, COLS*ROWS=19200 outputs, out_last on 19200th, frame_done one cycle later.
REQ-033 Address at row 21, col 88: in_pixel=12'hF0F, mask_en=1 -> out_pixel = 12'hF0F & rom_data(21,88); repeat with mask_en=0 -> out_pixel=12'hF0F.
REQ-034 Backpressure: out_ready=0 for 5 cycles mid-row -> in_ready=0, out_pixel/rom_col stable, no pixel lost or duplicated after release.
REQ-035 Row wrap: accept pixel at col 159 row 5 -> next rom_col=0, rom_row=6; final pixel (119,159) -> counters 0/0, state DRAIN.
REQ-036 start pulsed during RUN and in_valid during IDLE -> no effect; rst_n low at pixel 500 -> all outputs at reset values immediately, restart yields full 19200-pixel frame.
